// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (shift/rotate/add/logic, optional shift-add multiply) with valid/ready handshake.
// Latency: 1 cycle for single-cycle and reserved ops; WIDTH cycles for multiply (only when ALU_MUL_EN is defined).
// Backpressure: the result is held stable while out_valid && !out_ready; in_ready is low in BUSY and in a stalled DONE.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z,
    output logic             err
);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_q;
    logic               ofl_q;
    logic               z_q;
    logic               err_q;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] rot2;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_d;
    logic               ofl_d;
    logic               err_d;
    logic               accept;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [SW:0]        cnt_q;
    logic               is_mul;

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        is_mul = (Op == 4'h8);
    end
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign Ofl       = ofl_q;
    assign Z         = z_q;
    assign err       = err_q;

    // Single-cycle result for the op presented on the inputs; only latched on accept
    always_comb begin
        a     = invA ? ~A : A;
        b     = invB ? ~B : B;
        sh    = b[SW-1:0];
        rot2  = {a, a} << sh;
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Cin};
        res_d = '0;
        ofl_d = 1'b0;
        err_d = 1'b0;
        case (Op)
            4'h0: res_d = rot2[2*WIDTH-1:WIDTH];
            4'h1: res_d = a << sh;
            4'h2: res_d = $signed(a) >>> sh;
            4'h3: res_d = a >> sh;
            4'h4: begin
                res_d = sum[WIDTH-1:0];
                // signed: like-signed operands producing an opposite-signed result; unsigned: MSB carry-out
                ofl_d = sign ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                             : sum[WIDTH];
            end
            4'h5: res_d = a | b;
            4'h6: res_d = a ^ b;
            4'h7: res_d = a & b;
            // multiply (when enabled) never uses this path; otherwise it lands here as reserved
            default: err_d = 1'b1;
        endcase
    end

    // Control FSM with registered result outputs; an accept is only possible in IDLE or a draining DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ofl_q       <= 1'b0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
                state_q     <= S_BUSY;
                out_valid_q <= 1'b0;
                acc_q       <= '0;
                mcand_q     <= {{WIDTH{1'b0}}, a};
                mplier_q    <= b;
                cnt_q       <= (SW+1)'(WIDTH);
            end else
`endif
            begin
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
                out_q       <= res_d;
                ofl_q       <= ofl_d;
                z_q         <= (res_d == '0);
                err_q       <= err_d;
            end
        end else begin
            case (state_q)
`ifdef ALU_MUL_EN
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    // last step: publish the product straight from the adder
                    if (cnt_q == (SW+1)'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= acc_d[WIDTH-1:0];
                        ofl_q       <= |acc_d[2*WIDTH-1:WIDTH];
                        z_q         <= (acc_d[WIDTH-1:0] == '0);
                        err_q       <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the 16-bit datapath ALU. It adds a valid/ready handshake, registered results, reserved-op error reporting, and an optional iterative shift-add multiplier. It sits between the decode/operand stage and the writeback stage. The execute stage stalls on `in_ready` instead of assuming single-cycle completion.

## Interface
- `WIDTH`, default 16: datapath width; must be ≥4 and a power of two.
- `SW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request this cycle.
- `A`, `B` in WIDTH: operands.
- `Cin` in 1: carry-in (add only).
- `Op` in 4: operation select.
- `invA`, `invB` in 1: invert the operand before the operation.
- `sign` in 1: signed (1) / unsigned (0) overflow semantics.
- `out_valid` out 1: result registers hold a valid result.
- `out_ready` in 1: consumer takes the result this cycle.
- `Out` out WIDTH: registered result.
- `Ofl` out 1: registered overflow.
- `Z` out 1: registered, `Out == 0`.
- `err` out 1: registered; the op was reserved/unsupported.

## Operation
- **Operand conditioning:** `a = invA ? ~A : A`, `b = invB ? ~B : B`. This applies to every op. The shift amount is `b[SW-1:0]`.
- **Op encoding:**
  - 0000 rotate left
  - 0001 shift left logical
  - 0010 shift right arithmetic
  - 0011 shift right logical
  - 0100 `a+b+Cin`
  - 0101 OR
  - 0110 XOR
  - 0111 AND
  - 1000 multiply (low WIDTH bits of unsigned `a*b`)
  - 1001–1111 reserved
- **Add overflow:** when `sign`=1, `Ofl` = operands have the same sign and the result sign differs. When `sign`=0, `Ofl` = carry-out of the MSB.
- **Non-add overflow:** `Ofl`=0 for all ops except add and multiply.
- **Multiply:** always unsigned; `sign` is ignored. `Ofl` = upper WIDTH bits of the 2·WIDTH product are nonzero.
- **Multiply datapath:** shift-add, one multiplier bit per cycle, LSB first. Uses a 2·WIDTH accumulator and a bit counter.
- **Reserved ops:** `Out`=0, `Ofl`=0, `Z`=1, `err`=1, single-cycle latency.
- **FSM states:**
  - IDLE: if an accept occurs with a multiply op → BUSY (counter=WIDTH). If an accept occurs with any other op → DONE. Otherwise stay in IDLE.
  - BUSY: each cycle, decrement the counter and add/shift. When the counter reaches 0 → DONE.
  - DONE: `out_valid`=1. If `out_ready`=1 and there is a new accept → load the new op (DONE or BUSY). If `out_ready`=1 with no accept → IDLE. If `out_ready`=0 → hold.
- **Handshake:**
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - Accept = `in_valid && in_ready`.
  - Operands are captured at accept; later input changes have no effect.
- **Output stability:** `Out`, `Ofl`, `Z` and `err` are stable while `out_valid`=1 and `out_ready`=0.
- **Requests while busy:** `in_valid` during BUSY is ignored (`in_ready`=0).

## Timing
- **Reset values:** IDLE, `out_valid`=0, `Out`=0, `Ofl`=0, `Z`=0, `err`=0, `in_ready`=1 in the cycle after the reset edge.
- **Single-cycle ops:** accept at edge k → `out_valid`=1 after edge k (latency 1).
- **Throughput:**
  - Back-to-back single-cycle ops sustain 1 op per cycle while `out_ready`=1.
  - Multiply allows one op per WIDTH+1 cycles minimum.
- **Multiply latency:** accept at edge k → BUSY for WIDTH cycles → `out_valid`=1 after edge k+WIDTH. `in_ready`=0 from edge k until DONE.
- **Reset during BUSY or DONE:** the operation is aborted and the result discarded; `out_valid` is not asserted for it.
- **Reset priority:** reset wins over a simultaneous accept.

## Configuration
- **`ALU_MUL_EN` defined:** multiplier FSM path, counter and accumulator are compiled in. Op 1000 behaves as specified above.
- **`ALU_MUL_EN` undefined:** the BUSY state, counter and accumulator are absent. Op 1000 is treated as reserved (`Out`=0, `err`=1, latency 1), and `in_ready` never drops due to a multiply.

## Test plan
- **Add overflow:** WIDTH=16, add `A=0x7FFF`, `B=0x0001`, `Cin=0`.
  - With `sign=1`: `Out=0x8000`, `Ofl=1`, `Z=0`, `out_valid` 1 cycle after accept.
  - With `sign=0`: `Ofl=0`.
- **Shifts and rotate:**
  - Rotate left `A=0x8001`, `B=4` → `0x0018`.
  - SRA `A=0x8000`, `B=15` → `0xFFFF`.
  - SRL same operands → `0x0001`.
  - SLL `A=0x0001`, `B=0x0013` (amount 3) → `0x0008`.
- **Multiply (`ALU_MUL_EN`):**
  - `A=0x0100`, `B=0x0100` → `Out=0x0000`, `Ofl=1`, `Z=1`, `out_valid` exactly 16 cycles after accept, `in_ready`=0 throughout.
  - `A=0x00FF`, `B=0x0003` → `0x02FD`, `Ofl=0`.
- **Backpressure then streaming:**
  - XOR `A=0xFFFF`, `B=0x00FF` → `0xFF00`. Hold `out_ready=0` for 5 cycles: `Out` stable, `in_ready=0`.
  - Then 4 back-to-back AND ops with `out_ready=1`: 4 results on 4 consecutive cycles.
- **Reset mid-multiply:** assert `rst` at cycle 8 of a multiply → `out_valid` never rises, all outputs return to 0, `in_ready=1` the next cycle.
- **Reserved/disabled ops:**
  - `Op=1011` → `Out=0`, `Z=1`, `err=1`, latency 1.
  - Without `ALU_MUL_EN`, `Op=1000` → same response.
